// File: rtl/bpd_pht_port_ctrl.sv
// PHT single-port controller: arbitrates fetch reads against queued retire
// updates and sequences a full-table init sweep after reset or clear.
module bpd_pht_port_ctrl #(
    parameter int IDX_W  = 12,
    parameter int QDEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clr_i,
    input  logic                     fe_rd_i,
    input  logic                     rt_valid_i,
    input  logic [IDX_W-1:0]         rt_idx_i,
    input  logic                     rt_dir_i,
    output logic                     rt_ready_o,
    output logic                     pht_we_o,
    output logic [IDX_W-1:0]         pht_idx_o,
    output logic                     pht_dir_o,
    output logic                     pht_init_o,
    output logic                     fe_stall_o,
    output logic                     busy_o,
    output logic [$clog2(QDEPTH):0]  q_cnt_o,
    output logic                     drop_o
);

    localparam int PW = $clog2(QDEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(QDEPTH);

    typedef enum logic [1:0] {
        ST_START,
        ST_INIT,
        ST_RUN
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_sweep;
    logic [IDX_W-1:0] r_q_idx [QDEPTH];
    logic [QDEPTH-1:0] r_q_dir;
    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [PW:0]      r_cnt;
    logic [IDX_W-1:0] r_hold_idx;
    logic             r_hold_dir;

    logic             w_init;
    logic             w_run;
    logic             w_empty;
    logic             w_full;
    logic             w_ready;
    logic             w_grant;
    logic             w_we;
    logic             w_push;
    logic [IDX_W-1:0] w_idx;
    logic             w_dir;

    assign w_init  = (r_state == ST_INIT);
    assign w_run   = (r_state == ST_RUN);
    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == FULL);
    assign w_ready = w_init | (w_run & ~w_full);

    // A full queue steals the port from fetch so updates cannot starve.
    assign w_grant = w_run & ~w_empty & (~fe_rd_i | w_full);
    assign w_we    = w_init | w_grant;
    assign w_push  = w_run & rt_valid_i & ~w_full & ~clr_i;
    assign w_idx   = w_init ? r_sweep : r_q_idx[r_rp];
    assign w_dir   = w_init ? 1'b0 : r_q_dir[r_rp];

    assign rt_ready_o = w_ready;
    assign pht_we_o   = w_we;
    assign pht_init_o = w_init;
    assign pht_idx_o  = w_we ? w_idx : r_hold_idx;
    assign pht_dir_o  = w_we ? w_dir : r_hold_dir;
    assign fe_stall_o = fe_rd_i & w_we;
    assign busy_o     = ~w_run;
    assign q_cnt_o    = r_cnt;
    assign drop_o     = rt_valid_i & w_ready & (w_init | clr_i);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_START;
            r_sweep    <= '0;
            r_wp       <= '0;
            r_rp       <= '0;
            r_cnt      <= '0;
            r_q_dir    <= '0;
            r_hold_idx <= '0;
            r_hold_dir <= 1'b0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_idx[i] <= '0;
            end
        end else begin
            if (w_we) begin
                r_hold_idx <= w_idx;
                r_hold_dir <= w_dir;
            end
            if (clr_i) begin
                r_state <= ST_INIT;
                r_sweep <= '0;
                r_wp    <= '0;
                r_rp    <= '0;
                r_cnt   <= '0;
            end else begin
                unique case (r_state)
                    ST_START: begin
                        r_state <= ST_INIT;
                    end
                    ST_INIT: begin
                        r_sweep <= r_sweep + IDX_W'(1);
                        if (&r_sweep) begin
                            r_state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (w_push) begin
                            r_q_idx[r_wp] <= rt_idx_i;
                            r_q_dir[r_wp] <= rt_dir_i;
                            r_wp          <= r_wp + PW'(1);
                        end
                        if (w_grant) begin
                            r_rp <= r_rp + PW'(1);
                        end
                        r_cnt <= r_cnt + {{PW{1'b0}}, w_push}
                                       - {{PW{1'b0}}, w_grant};
                    end
                    default: begin
                        r_state <= ST_START;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bpd_pht_port_ctrl.sv
// Bench for bpd_pht_port_ctrl: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_bpd_pht_port_ctrl;

    localparam int IW = 8;
    localparam int QD = 4;
    localparam int CW = $clog2(QD) + 1;
    localparam int NENT = 1 << IW;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          clr_i = 1'b0;
    logic          fe_rd_i = 1'b0;
    logic          rt_valid_i = 1'b0;
    logic [IW-1:0] rt_idx_i = '0;
    logic          rt_dir_i = 1'b0;
    logic          rt_ready_o;
    logic          pht_we_o;
    logic [IW-1:0] pht_idx_o;
    logic          pht_dir_o;
    logic          pht_init_o;
    logic          fe_stall_o;
    logic          busy_o;
    logic [CW-1:0] q_cnt_o;
    logic          drop_o;

    bpd_pht_port_ctrl #(.IDX_W(IW), .QDEPTH(QD)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .clr_i      (clr_i),
        .fe_rd_i    (fe_rd_i),
        .rt_valid_i (rt_valid_i),
        .rt_idx_i   (rt_idx_i),
        .rt_dir_i   (rt_dir_i),
        .rt_ready_o (rt_ready_o),
        .pht_we_o   (pht_we_o),
        .pht_idx_o  (pht_idx_o),
        .pht_dir_o  (pht_dir_o),
        .pht_init_o (pht_init_o),
        .fe_stall_o (fe_stall_o),
        .busy_o     (busy_o),
        .q_cnt_o    (q_cnt_o),
        .drop_o     (drop_o)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: 0=start, 1=sweeping, 2=running
    int            m_mode;
    int            m_sweep;
    logic [IW:0]   m_q[$];
    logic [IW-1:0] m_hidx;
    logic          m_hdir;

    logic          e_we, e_dir, e_init, e_stall;
    logic          e_busy, e_ready, e_drop, e_wr;
    logic [IW-1:0] e_idx;
    int            e_cnt;

    task automatic model_reset();
        m_mode  = 0;
        m_sweep = 0;
        m_q.delete();
        m_hidx  = '0;
        m_hdir  = 1'b0;
    endtask

    task automatic calc();
        bit full;
        e_we = 0; e_dir = m_hdir; e_idx = m_hidx; e_init = 0;
        e_stall = 0; e_busy = 1; e_ready = 0; e_drop = 0;
        e_wr = 0; e_cnt = m_q.size();
        if (m_mode == 1) begin
            e_we    = 1;
            e_init  = 1;
            e_idx   = IW'(m_sweep);
            e_dir   = 0;
            e_stall = fe_rd_i;
            e_ready = 1;
            e_drop  = rt_valid_i;
        end else if (m_mode == 2) begin
            full    = (m_q.size() == QD);
            e_ready = !full;
            e_wr    = (m_q.size() > 0) && (!fe_rd_i || full);
            e_we    = e_wr;
            if (e_wr) begin
                e_idx = m_q[0][IW-1:0];
                e_dir = m_q[0][IW];
            end
            e_stall = fe_rd_i && e_wr;
            e_drop  = rt_valid_i && e_ready && clr_i;
            e_busy  = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t",
                   tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        calc();
        chk("we",    32'(pht_we_o),   32'(e_we));
        chk("idx",   32'(pht_idx_o),  32'(e_idx));
        chk("dir",   32'(pht_dir_o),  32'(e_dir));
        chk("init",  32'(pht_init_o), 32'(e_init));
        chk("stall", 32'(fe_stall_o), 32'(e_stall));
        chk("busy",  32'(busy_o),     32'(e_busy));
        chk("ready", 32'(rt_ready_o), 32'(e_ready));
        chk("drop",  32'(drop_o),     32'(e_drop));
        chk("qcnt",  32'(q_cnt_o),    32'(e_cnt));
    endtask

    task automatic model_edge();
        calc();
        if (!reset_n) return;
        if (e_we) begin
            m_hidx = e_idx;
            m_hdir = e_dir;
        end
        if (clr_i) begin
            m_mode  = 1;
            m_sweep = 0;
            m_q.delete();
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (m_sweep == NENT - 1) m_mode = 2;
            m_sweep = (m_sweep + 1) % NENT;
        end else begin
            if (e_wr) void'(m_q.pop_front());
            if (rt_valid_i && e_ready) m_q.push_back({rt_dir_i, rt_idx_i});
        end
    endtask

    task automatic drive(input logic fe, input logic v,
                         input logic [IW-1:0] idx, input logic dir,
                         input logic clr);
        fe_rd_i    = fe;
        rt_valid_i = v;
        rt_idx_i   = idx;
        rt_dir_i   = dir;
        clr_i      = clr;
    endtask

    task automatic cyc(input logic fe, input logic v,
                       input logic [IW-1:0] idx, input logic dir,
                       input logic clr);
        drive(fe, v, idx, dir, clr);
        @(negedge clock);
        check_all();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic rnd_cyc(input int fe_pct, input int clr_inv);
        cyc(($urandom_range(0, 99) < fe_pct), 1'($urandom),
            IW'($urandom), 1'($urandom),
            (clr_inv > 0) && ($urandom_range(0, clr_inv - 1) == 0));
    endtask

    initial begin
        model_reset();
        reset_n = 1'b0;
        repeat (3) cyc(1, 1, 8'h33, 1, 0);
        reset_n = 1'b1;

        // START then full sweep with random fetch/retire traffic
        repeat (NENT + 1) rnd_cyc(50, 0);
        repeat (2) cyc(0, 0, 0, 0, 0);

        // single update, minimum latency
        cyc(0, 1, 8'h5A, 1, 0);
        repeat (2) cyc(0, 0, 0, 0, 0);

        // fetch holds the port until the queue fills
        cyc(1, 1, 8'hA1, 1, 0);
        cyc(1, 1, 8'hB2, 0, 0);
        cyc(1, 1, 8'hC3, 1, 0);
        cyc(1, 1, 8'hD4, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0);

        // refill, then drain with continuous pushes
        cyc(1, 1, 8'hE5, 1, 0);
        repeat (6) cyc(0, 1, IW'($urandom), 1'($urandom), 0);
        repeat (5) cyc(0, 0, 0, 0, 0);

        // clear with three queued entries and a pending update
        repeat (3) cyc(1, 1, IW'($urandom), 1'($urandom), 0);
        cyc(1, 1, 8'h77, 1, 1);
        repeat (9) cyc(1, 0, 0, 0, 0);

        // clear again at sweep index 9, then finish the sweep
        cyc(1, 1, 8'h11, 0, 1);
        repeat (NENT + 3) rnd_cyc(50, 0);

        // async reset mid-sweep
        cyc(0, 0, 0, 0, 1);
        repeat (9) rnd_cyc(50, 0);
        drive(1, 1, 8'h22, 1, 0);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) cyc(1, 1, 8'h22, 1, 0);
        reset_n = 1'b1;
        repeat (NENT + 2) rnd_cyc(50, 0);

        // random traffic with occasional clears
        repeat (1500) rnd_cyc(75, 300);
        repeat (2) cyc(1, 1, IW'($urandom), 1'($urandom), 1);
        repeat (NENT + 2) rnd_cyc(40, 0);
        repeat (300) rnd_cyc(60, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
